// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU op codes (also used by the ALU),
// sequencer state encoding and the decoder output bundle.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLAC = 4'h1;
  localparam logic [3:0] OP_LDAC = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_STAC = 4'h7;
  localparam logic [3:0] OP_JMPZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [2:0] ALU_CLR  = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_MUL  = 3'd4;
  localparam logic [2:0] ALU_INC  = 3'd5;
  localparam logic [2:0] ALU_IDLE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD_IR,
    ST_EXEC,
    ST_JUMP
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ac_we;
    logic       reg_we;
    logic       is_jump;
    logic       is_cond;
    logic       is_end;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/core_decoder.sv
// Combinational instruction decode: ir -> ALU op, write enables, flow flags.
module core_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  // Opcode table; undefined opcodes look like NOP plus the illegal flag
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_IDLE;
    case (ir[7:4])
      OP_NOP:  ;
      OP_CLAC: begin dec.alu_op = ALU_CLR;  dec.ac_we = 1'b1; end
      OP_LDAC: begin dec.alu_op = ALU_PASS; dec.ac_we = 1'b1; end
      OP_ADD:  begin dec.alu_op = ALU_ADD;  dec.ac_we = 1'b1; end
      OP_SUB:  begin dec.alu_op = ALU_SUB;  dec.ac_we = 1'b1; end
      OP_MUL:  begin dec.alu_op = ALU_MUL;  dec.ac_we = 1'b1; end
      OP_INC:  begin dec.alu_op = ALU_INC;  dec.ac_we = 1'b1; end
      OP_STAC: dec.reg_we = 1'b1;
      OP_JMPZ: begin dec.is_jump = 1'b1; dec.is_cond = 1'b1; end
      OP_JMP:  dec.is_jump = 1'b1;
      OP_END:  dec.is_end = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Per-core instruction sequencer: fetch/decode FSM with start/done handshake.
// Control outputs are decodes of registered state (state, ir) only, so they
// have no combinational path from any input.
module core_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  input  logic            ac_zero,
  output logic [2:0]      alu_op,
  output logic [3:0]      reg_sel,
  output logic            ac_we,
  output logic            reg_we,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  dec_t            dec;
  logic            ex;

  core_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  // pc already points past the opcode word in EXEC, so it addresses the
  // jump target word there; in FETCH it addresses the instruction.
  assign imem_addr = pc;

  // Control outputs are live only during the single EXEC cycle
  assign ex      = (state == ST_EXEC);
  assign alu_op  = ex ? dec.alu_op : ALU_IDLE;
  assign ac_we   = ex & dec.ac_we;
  assign reg_we  = ex & dec.reg_we;
  assign reg_sel = (ac_we | reg_we) ? ir[3:0] : 4'd0;
  assign done    = ex & dec.is_end;
  assign busy    = (state != ST_IDLE);

  // Sequencer FSM, program counter, instruction register, sticky illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc      <= start_pc;
            illegal <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          pc    <= pc + PC_W'(1);
          state <= ST_LOAD_IR;
        end
        ST_LOAD_IR: begin
          ir    <= imem_rdata;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.is_illegal) illegal <= 1'b1;
          if (dec.is_jump)     state <= ST_JUMP;
          else if (dec.is_end) state <= ST_IDLE;
          else                 state <= ST_FETCH;
        end
        ST_JUMP: begin
          // Not-taken JMPZ skips over the target word
          if (!dec.is_cond || ac_zero) pc <= PC_W'(imem_rdata);
          else                         pc <= pc + PC_W'(1);
          state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with a behavioural synchronous imem.
module tb_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_pc = '0;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = '0;
  logic       ac_zero = 1'b0;
  logic [2:0] alu_op;
  logic [3:0] reg_sel;
  logic       ac_we, reg_we, busy, done, illegal;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  core_ctrl #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ac_zero(ac_zero),
    .alu_op(alu_op), .reg_sel(reg_sel), .ac_we(ac_we), .reg_we(reg_we),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory, one cycle read latency
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse start for one cycle; returns in the cycle after the sampling edge
  task automatic do_start(input logic [7:0] pc);
    start    = 1'b1;
    start_pc = pc;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_op"},  alu_op, 3'd6);
    chk({tag, "_acw"}, ac_we, 1'b0);
    chk({tag, "_rgw"}, reg_we, 1'b0);
  endtask

  int eop [4] = '{0, 5, 2, 6};
  int eac [4] = '{1, 1, 1, 0};
  int ers [4] = '{0, 0, 2, 0};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // main program
    mem[8'h10] = 8'h10; mem[8'h11] = 8'h60; mem[8'h12] = 8'h32; mem[8'h13] = 8'hF0;
    // conditional jump
    mem[8'h20] = 8'h80; mem[8'h21] = 8'h40; mem[8'h22] = 8'hF0; mem[8'h40] = 8'hF0;
    // illegal opcode then STAC r5
    mem[8'h30] = 8'hB3; mem[8'h31] = 8'h75; mem[8'h32] = 8'hF0;
    // unconditional jump across the top of memory
    mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h05; mem[8'h05] = 8'hF0;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ill", illegal, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_sel", reg_sel, 4'd0);
    chk_quiet("rst");
    rst_n = 1'b1;
    tick();

    // straight-line program, with a start pulse while busy that must be ignored
    do_start(8'h10);
    for (int c = 1; c <= 12; c++) begin
      chk("prog_busy", busy, 1'b1);
      chk("prog_done", done, (c == 12));
      if (c % 3 == 1) chk("prog_addr", imem_addr, 8'h10 + (c - 1) / 3);
      if (c % 3 == 0) begin
        chk("prog_op",  alu_op,  eop[c/3-1]);
        chk("prog_acw", ac_we,   eac[c/3-1]);
        chk("prog_sel", reg_sel, ers[c/3-1]);
      end else begin
        chk_quiet("prog_idle");
      end
      if (c == 5) begin
        start = 1'b1; start_pc = 8'h77;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    chk("prog_end_busy", busy, 1'b0);

    // JMPZ taken, started the cycle after done
    ac_zero = 1'b1;
    do_start(8'h20);
    chk("jz1_busy", busy, 1'b1);
    chk("jz1_fetch", imem_addr, 8'h20);
    tick(); tick();
    chk("jz1_tgt_addr", imem_addr, 8'h21);
    chk_quiet("jz1_exec");
    tick(); tick();
    chk("jz1_next", imem_addr, 8'h40);
    tick(); tick();
    chk("jz1_done", done, 1'b1);
    tick();

    // JMPZ not taken
    ac_zero = 1'b0;
    do_start(8'h20);
    repeat (4) tick();
    chk("jz0_next", imem_addr, 8'h22);
    repeat (2) tick();
    chk("jz0_done", done, 1'b1);
    tick();

    // JMP at 0xFE with target word at 0xFF
    ac_zero = 1'b1;
    do_start(8'hFE);
    repeat (4) tick();
    chk("jmp_next", imem_addr, 8'h05);
    repeat (3) tick();

    // NOP at 0xFF wraps to 0x00
    mem[8'hFF] = 8'h00; mem[8'h00] = 8'hF0;
    do_start(8'hFF);
    tick(); tick();
    chk_quiet("nop_exec");
    tick();
    chk("wrap_addr", imem_addr, 8'h00);
    repeat (2) tick();
    chk("wrap_done", done, 1'b1);
    tick();

    // undefined opcode: flags illegal, no writes, keeps running
    do_start(8'h30);
    tick(); tick();
    chk_quiet("ill_exec");
    chk("ill_pre", illegal, 1'b0);
    tick();
    chk("ill_set", illegal, 1'b1);
    chk("ill_cont", imem_addr, 8'h31);
    tick(); tick();
    chk("stac_rgw", reg_we, 1'b1);
    chk("stac_sel", reg_sel, 4'd5);
    chk("stac_op", alu_op, 3'd6);
    chk("stac_acw", ac_we, 1'b0);
    repeat (4) tick();
    chk("ill_sticky", illegal, 1'b1);
    chk("ill_idle", busy, 1'b0);

    // next start clears illegal; then reset mid-EXEC of ADD
    do_start(8'h10);
    chk("ill_clr", illegal, 1'b0);
    repeat (8) tick();
    chk("add_op", alu_op, 3'd2);
    chk("add_acw", ac_we, 1'b1);
    chk("add_sel", reg_sel, 4'd2);
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_sel", reg_sel, 4'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", imem_addr, 8'h00);
    chk("midrst_done", done, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Per-core instruction sequencer for the multicore CPU. Fetches 8-bit instructions from the core's instruction memory, decodes them, and drives the 3-bit ALU operation code plus accumulator/register-file write enables and register select for the core datapath. Started and stopped by the top-level core scheduler through a start/done handshake; one instance sits directly upstream of each core's ALU.

## Interface
- PC_W, 8, program counter / instruction-memory address width
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse from scheduler; honoured only when busy=0
- start_pc  in  PC_W  entry address sampled with start
- imem_addr  out  PC_W  instruction-memory read address
- imem_rdata  in  8  instruction word; synchronous memory, valid one cycle after imem_addr
- ac_zero  in  1  accumulator == 0, from datapath
- alu_op  out  3  ALU operation: 0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc, 6 idle
- reg_sel  out  4  register-file index for ALU operand B / store destination
- ac_we  out  1  accumulator load from ALU result
- reg_we  out  1  register-file write of accumulator into R[reg_sel]
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on END
- illegal  out  1  sticky: undefined opcode executed; cleared by next accepted start

## Operation
- Instruction format: op=[7:4], r=[3:0]. Opcodes: 0 NOP, 1 CLAC (alu_op clr), 2 LDAC r (pass), 3 ADD r, 4 SUB r, 5 MUL r, 6 INC, 7 STAC r, 8 JMPZ, 9 JMP, F END; A–E undefined.
- Jumps are two words: opcode word followed by a full 8-bit target word.
- States: IDLE, FETCH, LOAD_IR, EXEC, JUMP.
- IDLE: start -> pc<=start_pc, busy<=1, illegal<=0, go FETCH.
- FETCH: imem_addr=pc, pc<=pc+1, go LOAD_IR.
- LOAD_IR: ir<=imem_rdata, go EXEC.
- EXEC: ops 1–6 drive alu_op per table, reg_sel=r, ac_we=1, go FETCH. STAC: reg_sel=r, reg_we=1, alu_op idle, go FETCH. NOP: go FETCH. Undefined: illegal<=1, behaves as NOP. JMP/JMPZ: imem_addr=pc (target word), go JUMP. END: done=1, busy<=0, go IDLE.
- JUMP: JMP, or JMPZ with ac_zero=1 (sampled in JUMP) -> pc<=imem_rdata; else pc<=pc+1. Go FETCH.
- Outside EXEC of an ALU op: alu_op=6 (idle), ac_we=reg_we=0, reg_sel=0.
- pc arithmetic is modulo 2^PC_W; 0xFF+1 wraps to 0x00 silently.
- start while busy=1 is ignored; no queuing.

## Timing
- Reset (async, any state): state IDLE, pc=0, ir=0, imem_addr=0, alu_op=6, reg_sel=0, ac_we=0, reg_we=0, busy=0, done=0, illegal=0. Mid-instruction reset abandons it with no write enable issued.
- All outputs except imem_addr are registered-state decodes with no combinational path from inputs.
- Non-jump instruction: 3 cycles (FETCH, LOAD_IR, EXEC). Jump: 4 cycles. END: 3 cycles, done in the EXEC cycle.
- busy rises the cycle after start; done and busy falling coincide; a new start is accepted the cycle after done.
- Control outputs valid for exactly the one EXEC cycle; the datapath captures on the following edge.

## Structure
- cpu_pkg: opcode constants, ALU op constants (shared with the ALU), state enum.
- Sub-module core_decoder: combinational ir -> {alu_op, ac_we, reg_we, is_jump, is_cond, is_end, is_illegal}; core_ctrl holds the FSM, pc, and ir.

## Test plan
- Reset mid-EXEC of ADD -> all outputs return to reset values immediately; alu_op=6, ac_we=0.
- start_pc=0x10, program {0x1_0, 0x6_0, 0x3_2, 0xF_0} -> EXEC cycles show alu_op 0,5,2 with ac_we=1, reg_sel=2 on ADD; done 12 cycles after start; busy 1 throughout.
- JMPZ at 0x20 target 0x40, ac_zero=1 -> next fetch at 0x40; ac_zero=0 -> next fetch at 0x22.
- JMP at 0xFE, target word at 0xFF = 0x05 -> next fetch at 0x05; NOP at 0xFF run sequentially -> fetch wraps to 0x00.
- Opcode 0xB executed -> illegal=1, no write enables, execution continues; cleared by next start.
- start pulsed while busy -> ignored, pc unchanged; start in cycle after done -> accepted.
